riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared memory, ALU and register file over 3–5 cycles per instruction.
- Sits inside the multicycle processor top next to the datapath. Takes the opcode and funct fields from the instruction register and the ALU zero flag; drives every enable and mux select.

Parameters:
- none. State encoding is fixed: 4 bits, Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ExecuteI=7, ALUWB=8, JAL=9, BEQ=10.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU result == 0
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A register
- ALUSrcB  out  2  00=WriteData register, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- State  out  4  current state, for debug and bench checking

Behaviour:
- State register updates on the rising clk edge. reset=1 at an edge forces State=Fetch.
- While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 combinationally. This applies mid-instruction too: the instruction is abandoned with no further writes.
- Outputs are Moore decodes of State, with two exceptions: ALUControl also depends on funct3, op[5] and funct7b5; PCWrite = PCUpdate | (Branch & Zero).
- Unlisted outputs are 0 in every state.
- Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> Decode.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MemAdr
  - 0110011 -> ExecuteR
  - 0010011 -> ExecuteI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> Fetch (instruction skipped, no writes)
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=0000011 -> MemRead, else -> MemWrite.
- MemRead: ResultSrc=00, AdrSrc=1 -> MemWB.
- MemWB: ResultSrc=01, RegWrite=1 -> Fetch.
- MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1 -> Fetch.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> Fetch.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> Fetch.
- ImmSrc is combinational from op in every state: lw/I-type=00, sw=01, beq=10, jal=11, other=00.
- ALU decoder:
  - ALUOp=00 -> add; ALUOp=01 -> sub.
  - ALUOp=10, funct3=000: {op[5],funct7b5}=11 -> sub, else add.
  - ALUOp=10, funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- An unreachable State (11–15) goes to Fetch on the next edge.

Test Plan:
- Reset held 2 cycles, then released -> State=0 and IRWrite=1 on the first free cycle. While reset=1, all write enables are 0.
- lw (op=0000011) -> State sequence 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in state 4. AdrSrc=1 in state 3.
- sw (op=0100011) -> sequence 0,1,2,5,0. MemWrite=1 for exactly one cycle, with ImmSrc=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in state 6. Same with funct7b5=0 -> 000. funct3=111 -> 010.
- beq with Zero=1 -> PCWrite=1 in state 10. With Zero=0 -> PCWrite=0. Both cases -> ALUControl=001, ImmSrc=10, next State=0.
- jal -> sequence 0,1,9,8,0 with PCWrite=1 in state 9. Unknown op=1111111 -> 0,1,0. reset asserted in state 3 -> State=0 after the edge and RegWrite never pulses.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control unit: a Moore main FSM sequencing memory, ALU and
// register file, plus the ALU decoder and immediate-format decoder.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_e     state_q, state_d;
  logic       pc_update, branch;
  logic       mem_write_raw, ir_write_raw, reg_write_raw;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        // PC+4 from OldPC goes to rd via ALUWB; ALUOut (target) loads the PC
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held, even mid-instruction
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign MemWrite = ~reset & mem_write_raw;
  assign IRWrite  = ~reset & ir_write_raw;
  assign RegWrite = ~reset & reg_write_raw;
  assign State    = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // Only R-type with funct7b5 set is sub; addi ignores instr[30]
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench: expected per-cycle control vectors are queued with each
// instruction and popped/compared one per cycle at the falling edge.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  riscv_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] st, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic rw,
                      input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] imm,
                      input logic [2:0] alu);
    exp_t e;
    e = '{st, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
    sb_q.push_back(e);
  endtask

  // Compare current DUT outputs (1 time unit after the falling edge) with queue head
  task automatic check(input string tag);
    exp_t e, o;
    #1;
    o = '{State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
          ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty obs=%h", tag, o);
    end else begin
      e = sb_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s state=%0d obs=%h exp=%h", tag, e.st, o, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() > 0) begin
      check(tag);
      @(negedge clk);
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  // Common Fetch/Decode entries; ALUOp=00 -> add in both
  task automatic push_fd(input logic [1:0] imm);
    push(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
    push(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b1);
    // Reset held two cycles: Fetch with all write enables gated off
    @(negedge clk);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    check("reset_hold1");
    @(negedge clk);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    check("reset_hold2");
    reset = 1'b0;

    // lw: 0,1,2,3,4
    set_instr(OP_LW, 3'b010, 1'b0, 1'b1);
    push_fd(2'b00);
    push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    push(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("lw");

    // sw: 0,1,2,5
    set_instr(OP_SW, 3'b010, 1'b0, 1'b1);
    push_fd(2'b01);
    push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    push(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    drain("sw");

    // R-type sub / add / and
    set_instr(OP_R, 3'b000, 1'b1, 1'b1);
    push_fd(2'b00);
    push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("r_sub");

    set_instr(OP_R, 3'b000, 1'b0, 1'b0);
    push_fd(2'b00);
    push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("r_add");

    set_instr(OP_R, 3'b111, 1'b0, 1'b0);
    push_fd(2'b00);
    push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("r_and");

    set_instr(OP_R, 3'b110, 1'b0, 1'b0);
    push_fd(2'b00);
    push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("r_or");

    // addi with instr[30]=1 must still add (op[5]=0)
    set_instr(OP_I, 3'b000, 1'b1, 1'b1);
    push_fd(2'b00);
    push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("addi");

    set_instr(OP_I, 3'b010, 1'b0, 1'b0);
    push_fd(2'b00);
    push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("slti");

    set_instr(OP_I, 3'b100, 1'b0, 1'b0);
    push_fd(2'b00);
    push(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    drain("xori_default");

    // beq taken / not taken
    set_instr(OP_BEQ, 3'b000, 1'b0, 1'b1);
    push_fd(2'b10);
    push(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    drain("beq_taken");

    set_instr(OP_BEQ, 3'b000, 1'b0, 1'b0);
    push_fd(2'b10);
    push(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    drain("beq_not_taken");

    // jal: 0,1,9,8
    set_instr(OP_JAL, 3'b000, 1'b0, 1'b0);
    push_fd(2'b11);
    push(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
    drain("jal");

    // Unknown opcode: 0,1 then back to Fetch
    set_instr(OP_BAD, 3'b000, 1'b1, 1'b1);
    push_fd(2'b00);
    drain("illegal");

    // Reset asserted during MemRead of a lw
    set_instr(OP_LW, 3'b010, 1'b0, 1'b1);
    push_fd(2'b00);
    push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    drain("lw_pre_reset");
    reset = 1'b1;
    push(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    check("lw_reset_memread");
    @(negedge clk);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    check("lw_reset_abandon");
    @(negedge clk);
    reset = 1'b0;

    // Normal operation resumes after mid-instruction reset
    set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
    push_fd(2'b01);
    push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    push(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    push(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    drain("sw_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // RegWrite must never pulse while reset is held
  always @(negedge clk) begin
    if (reset === 1'b1 && RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL regwrite_during_reset obs=%b exp=0", RegWrite);
    end
  end

endmodule
